// File: rtl/fp8_dot_accum.sv
// ============================================================================
// fp8_dot_accum / fp8_e4m3_fma
// Sequential FP8 E4M3 dot-product engine around one single-cycle FMA.
// Optional ReLU on the result port: define FP8_DOT_RELU_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp8_e4m3_fma (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [7:0] i_c,
  output logic [7:0] o_y
);
  // Exact a*b+c in fixed point (LSB = 2^-18), then one round-to-nearest-even.
  localparam int c_W = 38;

  logic [3:0]     w_ea, w_eb, w_ec, w_ma, w_mb, w_mc;
  logic [7:0]     w_prod;
  logic [4:0]     w_psh;
  logic [c_W-1:0] w_p, w_c, w_m;
  logic           w_sp, w_s, w_g, w_st;
  logic [5:0]     w_lead, w_sh, w_e;
  logic [4:0]     w_q, w_rnd;
  logic [2:0]     w_mant;

  assign w_ea   = (i_a[6:3] == 4'd0) ? 4'd1 : i_a[6:3];
  assign w_eb   = (i_b[6:3] == 4'd0) ? 4'd1 : i_b[6:3];
  assign w_ec   = (i_c[6:3] == 4'd0) ? 4'd1 : i_c[6:3];
  assign w_ma   = {|i_a[6:3], i_a[2:0]};
  assign w_mb   = {|i_b[6:3], i_b[2:0]};
  assign w_mc   = {|i_c[6:3], i_c[2:0]};
  assign w_prod = {4'd0, w_ma} * {4'd0, w_mb};
  assign w_psh  = {1'b0, w_ea} + {1'b0, w_eb} - 5'd2;
  assign w_p    = {30'd0, w_prod} << w_psh;
  assign w_c    = {34'd0, w_mc} << ({1'b0, w_ec} + 5'd8);
  assign w_sp   = i_a[7] ^ i_b[7];

  always_comb begin
    w_s    = w_sp;
    w_m    = '0;
    w_lead = 6'd0;
    w_sh   = 6'd9;
    w_q    = 5'd0;
    w_g    = 1'b0;
    w_st   = 1'b0;
    w_rnd  = 5'd0;
    w_e    = 6'd0;
    w_mant = 3'd0;
    o_y    = 8'h00;
    if (w_sp == i_c[7]) begin
      w_m = w_p + w_c;
    end else if (w_p >= w_c) begin
      w_m = w_p - w_c;
    end else begin
      w_m = w_c - w_p;
      w_s = i_c[7];
    end
    for (int i = 0; i < c_W; i++) begin
      if (w_m[i]) w_lead = 6'(i);
    end
    // Mantissa LSB sits at bit w_sh; floor of 9 is the subnormal grid.
    w_sh  = (w_lead > 6'd12) ? w_lead - 6'd3 : 6'd9;
    w_q   = 5'(w_m >> w_sh);
    w_g   = w_m[w_sh - 6'd1];
    w_st  = |(w_m & ((38'd1 << (w_sh - 6'd1)) - 38'd1));
    w_rnd = w_q + {4'd0, w_g & (w_st | w_q[0])};
    if (w_rnd[4]) begin
      w_e = w_sh - 6'd7;
    end else if (w_rnd[3]) begin
      w_e    = w_sh - 6'd8;
      w_mant = w_rnd[2:0];
    end else begin
      w_mant = w_rnd[2:0];
    end
    if (w_m == '0)        o_y = 8'h00;
    else if (w_e > 6'd15) o_y = {w_s, 7'h7F};
    else                  o_y = {w_s, w_e[3:0], w_mant};
  end
endmodule

module fp8_dot_accum #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       init_c,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_acc;
  logic [LEN_W-1:0] r_cnt, r_len;
  logic [7:0]       w_fma;
  logic             w_beat, w_last;

  fp8_e4m3_fma u_fma (
    .i_a (in_a),
    .i_b (in_b),
    .i_c (r_acc),
    .o_y (w_fma)
  );

  assign w_beat = (r_state == S_ACCUM) && in_valid;
  assign w_last = (r_cnt == r_len - LEN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (len != '0) ? S_ACCUM : S_DONE;
      S_ACCUM: if (w_beat && w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 8'h00;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_acc <= init_c;
        if (len != '0) begin
          r_len <= len;
          r_cnt <= '0;
        end
      end else if (w_beat) begin
        r_acc <= w_fma;
        r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

`ifdef FP8_DOT_RELU_EN
  assign out_data = r_acc[7] ? 8'h00 : r_acc;
`else
  assign out_data = r_acc;
`endif
endmodule

`default_nettype wire
